// File: rtl/fp_pkg.sv
// Shared floating-point datapath definitions: rounding modes, flag bit positions
// and the product-width helper used by the multiplier normaliser and adder normaliser.
package fp_pkg;

    localparam logic RND_RNE = 1'b0;
    localparam logic RND_RTZ = 1'b1;

    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_INX = 0;

    // Full product width of two mantissas with hidden bits restored.
    function automatic int prod_w(input int man_w);
        return 2 * (man_w + 1);
    endfunction

endpackage

// File: rtl/fp_round_unit.sv
// Combinational round / range-check stage: applies RNE or RTZ, renormalises a
// rounding carry, then resolves zero > overflow > underflow > normal.
module fp_round_unit
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                     sign,
    input  logic signed [EXP_W+2:0]  e,
    input  logic [MAN_W-1:0]         man,
    input  logic                     guard,
    input  logic                     sticky,
    input  logic                     zero,
    input  logic                     rnd_mode,
    output logic [EXP_W+MAN_W:0]     result,
    output logic [2:0]               flags
);

    localparam int EW = EXP_W + 3;
    localparam logic [EW-1:0] EMAX = EW'((1 << EXP_W) - 1);

    logic                  inc;
    logic                  carry;
    logic [MAN_W-1:0]      man_r;
    logic signed [EW-1:0]  e_r;
    logic                  ovf;
    logic                  unf;

    always_comb begin
        inc = (rnd_mode == RND_RNE) && guard && (sticky || man[0]);
        {carry, man_r} = {1'b0, man} + {{MAN_W{1'b0}}, inc};
        // A carry out of all-ones leaves man_r at zero, so only the exponent moves.
        e_r = e + {{(EW-1){1'b0}}, carry};
        ovf = !e_r[EW-1] && ($unsigned(e_r) >= EMAX);
        unf = e_r[EW-1] || (e_r == '0);

        result = '0;
        flags  = '0;
        if (zero) begin
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else if (ovf) begin
            flags[FLG_OVF] = 1'b1;
            flags[FLG_INX] = 1'b1;
            if (rnd_mode == RND_RTZ)
                result = {sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
            else
                result = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (unf) begin
            flags[FLG_UNF] = 1'b1;
            flags[FLG_INX] = 1'b1;
            result = {sign, {(EXP_W+MAN_W){1'b0}}};
        end else begin
            flags[FLG_INX] = guard | sticky;
            result = {sign, e_r[EXP_W-1:0], man_r};
        end
    end

endmodule

// File: rtl/fp_mul_norm_pipe.sv
// Two-stage normalise/round pipeline for the FP multiplier with valid/ready
// flow control; stage 2 is the output register, so stalls back up into stage 1.
module fp_mul_norm_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 5,
    parameter int MAN_W = 10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_sign,
    input  logic [EXP_W+1:0]            in_exp,
    input  logic [2*(MAN_W+1)-1:0]      in_prod,
    input  logic                        rnd_mode,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [EXP_W+MAN_W:0]        out_result,
    output logic [2:0]                  out_flags
);

    localparam int PW = prod_w(MAN_W);
    localparam int EW = EXP_W + 3;

    logic [2:1]            vld_pipe;
    logic                  s2_adv;
    logic                  s1_adv;

    logic                  s1_sign, s1_guard, s1_sticky, s1_zero, s1_rnd;
    logic signed [EW-1:0]  s1_e;
    logic [MAN_W-1:0]      s1_man;

    logic                  n_guard, n_sticky;
    logic signed [EW-1:0]  n_e;
    logic [MAN_W-1:0]      n_man;

    logic [EXP_W+MAN_W:0]  rnd_result;
    logic [2:0]            rnd_flags;

    assign s2_adv    = !vld_pipe[2] || out_ready;
    assign s1_adv    = s2_adv;
    assign in_ready  = !vld_pipe[1] || s1_adv;
    assign out_valid = vld_pipe[2];

    // Exponent is widened by one bit so +1 here and the rounding carry never wrap.
    always_comb begin
        n_e = {in_exp[EXP_W+1], in_exp};
        if (in_prod[PW-1]) begin
            n_man    = in_prod[PW-2:MAN_W+1];
            n_guard  = in_prod[MAN_W];
            n_sticky = |in_prod[MAN_W-1:0];
            n_e      = n_e + EW'(1);
        end else begin
            n_man    = in_prod[PW-3:MAN_W];
            n_guard  = in_prod[MAN_W-1];
            n_sticky = |in_prod[MAN_W-2:0];
        end
    end

    fp_round_unit #(.EXP_W(EXP_W), .MAN_W(MAN_W)) u_round (
        .sign     (s1_sign),
        .e        (s1_e),
        .man      (s1_man),
        .guard    (s1_guard),
        .sticky   (s1_sticky),
        .zero     (s1_zero),
        .rnd_mode (s1_rnd),
        .result   (rnd_result),
        .flags    (rnd_flags)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_pipe   <= '0;
            s1_sign    <= 1'b0;
            s1_e       <= '0;
            s1_man     <= '0;
            s1_guard   <= 1'b0;
            s1_sticky  <= 1'b0;
            s1_zero    <= 1'b0;
            s1_rnd     <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (in_ready) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_sign   <= in_sign;
                    s1_e      <= n_e;
                    s1_man    <= n_man;
                    s1_guard  <= n_guard;
                    s1_sticky <= n_sticky;
                    s1_zero   <= (in_prod[PW-1:PW-2] == 2'b00);
                    s1_rnd    <= rnd_mode;
                end
            end
            // Output data only loads on an advance, which keeps it frozen under stall.
            if (s2_adv) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    out_result <= rnd_result;
                    out_flags  <= rnd_flags;
                end
            end
        end
    end

endmodule

// File: tb/tb_fp_mul_norm_pipe.sv
// Bench for fp_mul_norm_pipe: directed corner beats, backpressure, reset mid-stall
// and random beats scored in order against an arithmetic reference model.
module tb_fp_mul_norm_pipe;

    localparam int EXP_W = 5;
    localparam int MAN_W = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [6:0]  in_exp;
    logic [21:0] in_prod;
    logic        rnd_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] out_result;
    logic [2:0]  out_flags;

    int          n_asserts = 0;
    int          n_fail    = 0;
    logic [18:0] exp_q[$];
    bit          rand_bp   = 0;
    int          bp_cnt    = 0;
    bit          stall_prev = 0;
    logic [18:0] stall_val;

    always #5 clk = ~clk;

    fp_mul_norm_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_sign    (in_sign),
        .in_exp     (in_exp),
        .in_prod    (in_prod),
        .rnd_mode   (rnd_mode),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_asserts++;
        assert (got === want) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, want);
        end
    endtask

    // Value-level model: scale the product to an 11-bit integer significand,
    // round on the discarded remainder versus one half, then range check.
    function automatic logic [18:0] model(input logic s, input int ex, input int p, input logic rtz);
        int sh, e, q, rem, half;
        if (p < (1 << 20)) return {3'b000, s, 15'd0};
        sh   = (p >= (1 << 21)) ? 11 : 10;
        e    = ex + sh - 10;
        q    = p >> sh;
        rem  = p - (q << sh);
        half = 1 << (sh - 1);
        if (!rtz && (rem > half || (rem == half && q[0]))) q++;
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return rtz ? {3'b101, s, 5'b11110, 10'h3FF} : {3'b101, s, 5'h1F, 10'h000};
        if (e <= 0) return {3'b011, s, 15'd0};
        return {2'b00, rem != 0, s, e[4:0], q[9:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_bp) out_ready = ($urandom_range(0, 3) != 0);
        if (bp_cnt > 0) begin
            bp_cnt--;
            if (bp_cnt == 0) out_ready = 1'b1;
        end
    endtask

    task automatic send(input logic s, input int ex, input int p, input logic rtz, input logic [18:0] want);
        bit done = 0;
        in_valid = 1'b1;
        in_sign  = s;
        in_exp   = 7'(ex);
        in_prod  = 22'(p);
        rnd_mode = rtz;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (in_ready) begin
                done = 1;
                exp_q.push_back(want);
            end
            tick();
        end
        chk("accept", 32'(done), 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        logic s, rtz;
        int ex, p;
        s   = 1'($urandom_range(0, 1));
        rtz = 1'($urandom_range(0, 1));
        ex  = int'($urandom_range(0, 44)) - 6;
        if ($urandom_range(0, 9) == 0) p = int'($urandom_range(0, (1 << 20) - 1));
        else                           p = int'($urandom_range(1 << 20, (1 << 22) - 1));
        send(s, ex, p, rtz, model(s, ex, p, rtz));
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) tick();
        chk("drained", 32'(exp_q.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
        end else begin
            if (stall_prev && out_valid) chk("hold", {13'd0, out_flags, out_result}, {13'd0, stall_val});
            if (out_valid && out_ready) begin
                chk("queue_nonempty", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) chk("result", {13'd0, out_flags, out_result}, {13'd0, exp_q.pop_front()});
            end
            stall_prev = out_valid && !out_ready;
            stall_val  = {out_flags, out_result};
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_prod = '0;
        rnd_mode = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_result", 32'(out_result), 32'd0);
        chk("rst_out_flags", 32'(out_flags), 32'd0);
        rst = 1'b0;
        tick();
        chk("in_ready_after_rst", 32'(in_ready), 32'd1);

        // 1.5 x 1.5 with latency check
        send(1'b0, 15, 'h240000, 1'b0, {3'b000, 16'h4080});
        chk("lat1_valid", 32'(out_valid), 32'd0);
        tick();
        chk("lat2_valid", 32'(out_valid), 32'd1);
        tick();

        send(1'b0, 15, 'h100600, 1'b0, {3'b001, 16'h3C02});
        send(1'b0, 15, 'h100200, 1'b0, {3'b001, 16'h3C00});
        send(1'b0, 15, 'h100600, 1'b1, {3'b001, 16'h3C01});
        send(1'b0, 15, 'h1FFE00, 1'b0, {3'b001, 16'h4000});
        send(1'b1, 30, 'h200000, 1'b0, {3'b101, 16'hFC00});
        send(1'b1, 30, 'h200000, 1'b1, {3'b101, 16'hFBFF});
        send(1'b0, 0,  'h100000, 1'b0, {3'b011, 16'h0000});
        send(1'b1, 20, 'h000000, 1'b0, {3'b000, 16'h8000});
        send(1'b0, -3, 'h0C0000, 1'b1, {3'b000, 16'h0000});
        drain();

        // Backpressure: downstream stalled for 4 cycles across 4 beats
        out_ready = 1'b0;
        bp_cnt = 4;
        send(1'b0, 15, 'h240000, 1'b0, {3'b000, 16'h4080});
        send(1'b1, 15, 'h100600, 1'b0, {3'b001, 16'hBC02});
        chk("bp_in_ready_low", 32'(in_ready), 32'd0);
        send(1'b0, 15, 'h1FFE00, 1'b0, {3'b001, 16'h4000});
        send(1'b1, 30, 'h200000, 1'b1, {3'b101, 16'hFBFF});
        drain();

        // Random beats with random downstream stalls
        rand_bp = 1;
        repeat (80) send_rand();
        rand_bp = 0;
        tick();
        out_ready = 1'b1;
        drain();

        // Reset asserted during a stall drops out_valid without a clock edge
        out_ready = 1'b0;
        send_rand();
        send_rand();
        tick();
        chk("stall_valid", 32'(out_valid), 32'd1);
        #2 rst = 1'b1;
        #1 chk("rst_async_valid", 32'(out_valid), 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        tick();
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        send(1'b0, 15, 'h240000, 1'b0, {3'b000, 16'h4080});
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/fp_mul_norm_pipe.md
# fp_mul_norm_pipe

Parameterised, pipelined normaliser and rounder for the floating-point multiplier datapath. It takes a raw mantissa product and a pre-biased exponent sum from the multiplier array, then normalises the product and applies round-to-nearest-even or round-toward-zero. It also detects overflow, underflow and inexact results, and outputs a packed IEEE-style result with sign. It sits between the mantissa multiplier and the systolic accumulate stage. It adds valid/ready flow control, so downstream stalls propagate back into the array.

## Interface
- `EXP_W`, default 5: result exponent width.
- `MAN_W`, default 10: stored mantissa width, with the hidden bit excluded. `PW = 2*(MAN_W+1)` is the product width.
- `clk`  in  1: clock. Everything is rising-edge.
- `rst`  in  1: asynchronous, active-high reset.
- `in_valid`  in  1: input beat present.
- `in_ready`  out  1: block accepts a beat this cycle.
- `in_sign`  in  1: result sign, already XORed upstream.
- `in_exp`  in  `EXP_W+2`: two's-complement biased exponent sum, `ea+eb-BIAS`.
- `in_prod`  in  `PW`: unsigned mantissa product, with hidden bits included.
- `rnd_mode`  in  1: 0 = RNE, 1 = RTZ. Sampled with the beat.
- `out_valid`  out  1: result present.
- `out_ready`  in  1: downstream accepts.
- `out_result`  out  `1+EXP_W+MAN_W`: result packed as {sign, exp, man}.
- `out_flags`  out  3: {overflow, underflow, inexact}.

## Operation
- **Transfer rule.** A beat transfers when valid and ready are both high.
- **Stage 1, normalise.**
  - If `P[PW-1]`: mantissa = `P[PW-2:MAN_W+1]`, guard = `P[MAN_W]`, sticky = OR of `P[MAN_W-1:0]`, and e = `in_exp+1`.
  - Otherwise: mantissa = `P[PW-3:MAN_W]`, guard = `P[MAN_W-1]`, sticky = OR of `P[MAN_W-2:0]`, and e = `in_exp`.
  - If `P[PW-1:PW-2]==0`, the beat is marked zero.
- **Stage 2, round and range check.**
  - Under RNE, increment when guard is set and either sticky or the mantissa lsb is set. RTZ never increments.
  - If the increment carries out of a mantissa of all ones, the mantissa becomes 0 and e increments by 1.
  - inexact = guard OR sticky.
- **Zero beat.** Output is {sign, 0, 0} with flags 000.
- **Overflow** (e ≥ 2^EXP_W−1, signed compare):
  - RNE gives ±infinity: exp all ones, man 0.
  - RTZ gives ±max-finite: exp = all ones − 1, man all ones.
  - Flags are overflow=1, inexact=1.
- **Underflow** (e ≤ 0): flush to signed zero. Flags are underflow=1, inexact=1. Subnormals are not produced.
- **Otherwise:** exp = e[EXP_W-1:0], underflow=0, overflow=0.
- **Flag priority:** zero > overflow > underflow > normal.
- **Reset:** `out_valid`=0, `out_result`=0, `out_flags`=0, and both stage valid bits are 0. `in_ready` is 1 from the first cycle after reset release.

## Timing
- **Latency:** 2 cycles from input transfer to `out_valid` when there is no stall. Throughput is one beat per cycle.
- **Stage 2** holds its data while `out_valid && !out_ready`.
- **Stage 1** advances when stage 2 is empty or stage 2 is transferring.
- **`in_ready`:**
  - `in_ready = !s1_valid || s1_advance`.
  - It is combinational from `out_ready`; no skid buffer.
  - Up to 2 beats are held during a stall, and order is preserved.
- **Simultaneous events:** an output transfer and an input accept in the same cycle both occur with no bubble.
- **Output stability:** `out_result` and `out_flags` stay stable while `out_valid` is high and `out_ready` is low.
- **Reset mid-operation:** in-flight beats are discarded and `out_valid` drops asynchronously.

## Structure
- **Shared package `fp_pkg`:**
  - `RND_RNE`/`RND_RTZ` constants.
  - Flag bit indices: `FLG_OVF=2`, `FLG_UNF=1`, `FLG_INX=0`.
  - Width-derivation helper for PW.
- **Sub-module `fp_round_unit`:** combinational stage-2 logic, covering rounding, carry renormalisation, range check and flag priority. It is reused by the adder normaliser.

## Test plan
Parameters are the defaults, `EXP_W=5` and `MAN_W=10`; products are 22-bit.
- **1.5×1.5:** `in_exp`=15, `in_prod`=0x240000, RNE → `out_result`=0x4080, flags 000, valid 2 cycles later.
- **Tie, odd lsb:** `in_prod`=0x100600, `in_exp`=15, RNE → 0x3C02, inexact. Tie, even lsb, `in_prod`=0x100200 → 0x3C00, inexact. The same odd-lsb beat with RTZ → 0x3C01.
- **Rounding carry:** `in_prod`=0x1FFE00, `in_exp`=15, RNE → 0x4000, inexact.
- **Overflow:** `in_exp`=30, `in_prod`=0x200000, sign 1.
  - RNE → 0xFC00, flags 101.
  - RTZ → 0xFBFF, flags 101.
- **Underflow:** `in_exp`=0, `in_prod`=0x100000 → 0x0000, flags 011.
- **Zero:** `in_prod`=0 with any `in_exp` → signed zero, flags 000.
- **Backpressure:** 4 back-to-back beats with `out_ready`=0 for 4 cycles.
  - `in_ready` falls after 2 accepted beats.
  - All 4 results emerge in order, with no duplicates or drops.
  - Asserting `rst` mid-stall clears `out_valid` immediately.
